// File: rtl/mem_burst_addr_gen_pkg.sv
//------------------------------------------------------------------------------
// Package : sourcemux / cache_types
// Brief   : Shared request-source and burst-mode types for the line-fill path.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sourcemux;
    typedef enum logic {
        SRC_MEMORY = 1'b0,
        SRC_CACHE  = 1'b1
    } sourcemux_sel_t;
endpackage

package cache_types;
    typedef sourcemux::sourcemux_sel_t sourcemux_sel_t;

    typedef enum logic {
        BURST_LINEAR = 1'b0,
        BURST_WRAP   = 1'b1
    } burst_mode_t;
endpackage

`default_nettype wire

// File: rtl/line_base_sel.sv
//------------------------------------------------------------------------------
// Module  : line_base_sel
// Brief   : Selects the cache-line base address for a burst from its source.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module line_base_sel
    import cache_types::*;
#(
    parameter  int ADDR_W   = 32,
    parameter  int INDEX_W  = 3,
    parameter  int OFFSET_W = 5,
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  sourcemux::sourcemux_sel_t req_src,
    input  logic [ADDR_W-1:0]         mem_address,
    input  logic [TAG_W-1:0]          tag,
    input  logic [INDEX_W-1:0]        index,
    output logic [ADDR_W-1:0]         base
);

    localparam logic [ADDR_W-1:0] c_line_mask = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    always_comb begin
        base = mem_address & c_line_mask;
        if (req_src == sourcemux::SRC_CACHE) begin
            base = {tag, index, {OFFSET_W{1'b0}}};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_burst_addr_gen.sv
//------------------------------------------------------------------------------
// Module  : mem_burst_addr_gen
// Brief   : Generates per-beat memory addresses for cache-line fill and
//           write-back bursts, linear or critical-word-first.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_burst_addr_gen
    import cache_types::*;
#(
    parameter  int ADDR_W    = 32,
    parameter  int INDEX_W   = 3,
    parameter  int OFFSET_W  = 5,
    parameter  int BEAT_W    = 3,
    localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W,
    localparam int CNT_W     = OFFSET_W - BEAT_W,
    localparam int NUM_BEATS = 2 ** CNT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  sourcemux::sourcemux_sel_t req_src,
    input  burst_mode_t               req_mode,
    input  logic [ADDR_W-1:0]         mem_address,
    input  logic [TAG_W-1:0]          tag,
    input  logic [INDEX_W-1:0]        index,
    output logic                      beat_valid,
    input  logic                      beat_ready,
    output logic [ADDR_W-1:0]         beat_addr,
    output logic [CNT_W-1:0]          beat_idx,
    output logic                      beat_last,
    output logic                      busy,
    output logic                      done
);

    if (NUM_BEATS < 2) begin : g_param_check
        $error("mem_burst_addr_gen: a line must span at least two beats");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(NUM_BEATS - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_start;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done;

    logic [ADDR_W-1:0] w_base;
    logic [CNT_W-1:0]  w_start;
    logic              w_accept;
    logic              w_beat_hs;

    line_base_sel #(
        .ADDR_W   (ADDR_W),
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W)
    ) u_line_base_sel (
        .req_src     (req_src),
        .mem_address (mem_address),
        .tag         (tag),
        .index       (index),
        .base        (w_base)
    );

    // Write-backs always stream the victim line in order; only fills wrap.
    assign w_start = (req_src == sourcemux::SRC_MEMORY && req_mode == BURST_WRAP)
                   ? mem_address[OFFSET_W-1:BEAT_W] : '0;

    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state == ST_BURST);
    assign beat_valid = busy;
    assign w_accept   = req_valid && req_ready;
    assign w_beat_hs  = beat_valid && beat_ready;

    // Last-beat detection uses the handshake count, so the wrap point of the
    // beat index never affects burst length.
    assign beat_last  = busy && (r_cnt == c_cnt_last);
    assign beat_idx   = r_start + r_cnt;
    assign beat_addr  = r_base | ({{(ADDR_W-CNT_W){1'b0}}, beat_idx} << BEAT_W);
    assign done       = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_next = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_beat_hs && beat_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base  <= '0;
            r_start <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_beat_hs && beat_last;
            if (w_accept) begin
                r_base  <= w_base;
                r_start <= w_start;
                r_cnt   <= '0;
            end else if (w_beat_hs) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

endmodule

`default_nettype wire
